proc_control_unit: RTL and testbench

- Hardwired control unit for the single-core processor.
- Moore FSM that takes IR from the datapath and generates, one step per clk cycle, the register-transfer strobes (PCout, MARin, IncPC, Zin, Gra/Grb/Grc, Rin/Rout, BAout, Cout, ...) that drive proc.
- Runs fetch (T0–T2) followed by the opcode-specific execute steps, then returns to T0.
- Other end of the datapath control interface: it sources the strobes the datapath consumes.

---
 rtl/proc_ctrl_pkg.sv | 77 +++++++
 rtl/proc_ctrl_opclass.sv | 40 ++++
 rtl/proc_control_unit.sv | 260 ++++++++++++++++++++++++++
 tb/tb_proc_control_unit.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_ctrl_pkg.sv
// Shared definitions for the hardwired processor control unit.
//   - Opcode constants (IR[31:27])
//   - ALU codes used by the control unit
//   - Step encoding (T0..T7, HALT) and opcode-class encoding
//   - Packed strobe bundle plus the T0 fetch helper
package proc_ctrl_pkg;

  localparam int unsigned OpcodeW = 5;

  localparam logic [OpcodeW-1:0] OpLd   = 5'b00000;
  localparam logic [OpcodeW-1:0] OpLdi  = 5'b00001;
  localparam logic [OpcodeW-1:0] OpSt   = 5'b00010;
  localparam logic [OpcodeW-1:0] OpAdd  = 5'b00011;
  localparam logic [OpcodeW-1:0] OpSub  = 5'b00100;
  localparam logic [OpcodeW-1:0] OpShr  = 5'b00101;
  localparam logic [OpcodeW-1:0] OpShl  = 5'b00110;
  localparam logic [OpcodeW-1:0] OpRor  = 5'b00111;
  localparam logic [OpcodeW-1:0] OpRol  = 5'b01000;
  localparam logic [OpcodeW-1:0] OpAnd  = 5'b01001;
  localparam logic [OpcodeW-1:0] OpOr   = 5'b01010;
  localparam logic [OpcodeW-1:0] OpAddi = 5'b01011;
  localparam logic [OpcodeW-1:0] OpAndi = 5'b01100;
  localparam logic [OpcodeW-1:0] OpOri  = 5'b01101;
  localparam logic [OpcodeW-1:0] OpBr   = 5'b10010;
  localparam logic [OpcodeW-1:0] OpJr   = 5'b10011;
  localparam logic [OpcodeW-1:0] OpNop  = 5'b11001;
  localparam logic [OpcodeW-1:0] OpHalt = 5'b11010;

  // ALU codes coincide with the opcodes of the matching R-type instructions.
  localparam logic [OpcodeW-1:0] AluAdd = OpAdd;
  localparam logic [OpcodeW-1:0] AluAnd = OpAnd;
  localparam logic [OpcodeW-1:0] AluOr  = OpOr;

  typedef enum logic [3:0] {
    StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalt
  } step_e;

  typedef enum logic [3:0] {
    ClsNop, ClsLd, ClsLdi, ClsSt, ClsRtype, ClsImm, ClsBr, ClsJr, ClsHalt
  } op_class_e;

  typedef struct packed {
    logic pc_out;
    logic pc_in;
    logic inc_pc;
    logic mar_in;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic read;
    logic write;
    logic z_in;
    logic zlow_out;
    logic zhigh_out;
    logic y_in;
    logic c_out;
    logic ba_out;
    logic con_in;
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic r_out;
  } strobes_t;

  // First fetch step: PC to MAR and start PC+1 in the ALU.
  function automatic strobes_t fetch_t0_strobes();
    strobes_t s;
    s        = '0;
    s.pc_out = 1'b1;
    s.mar_in = 1'b1;
    s.inc_pc = 1'b1;
    s.z_in   = 1'b1;
    return s;
  endfunction

endpackage

// File: rtl/proc_ctrl_opclass.sv
// Combinational opcode decoder for the control unit.
//   opcode_i     : IR[31:27]
//   op_class_o   : execute-sequence class; unlisted opcodes fold into ClsNop
//   imm_alu_op_o : ALU code for the immediate forms (addi/andi/ori)
module proc_ctrl_opclass
  import proc_ctrl_pkg::*;
(
  input  logic [OpcodeW-1:0] opcode_i,
  output op_class_e          op_class_o,
  output logic [OpcodeW-1:0] imm_alu_op_o
);

  always_comb begin
    op_class_o   = ClsNop;
    imm_alu_op_o = AluAdd;
    case (opcode_i)
      OpLd:   op_class_o = ClsLd;
      OpLdi:  op_class_o = ClsLdi;
      OpSt:   op_class_o = ClsSt;
      OpAdd, OpSub, OpShr, OpShl, OpRor, OpRol, OpAnd, OpOr: op_class_o = ClsRtype;
      OpAddi: begin
        op_class_o   = ClsImm;
        imm_alu_op_o = AluAdd;
      end
      OpAndi: begin
        op_class_o   = ClsImm;
        imm_alu_op_o = AluAnd;
      end
      OpOri: begin
        op_class_o   = ClsImm;
        imm_alu_op_o = AluOr;
      end
      OpBr:   op_class_o = ClsBr;
      OpJr:   op_class_o = ClsJr;
      OpHalt: op_class_o = ClsHalt;
      default: op_class_o = ClsNop;  // nop, mul, div, neg, not, jal, in, out, mf*, reserved
    endcase
  end

endmodule

// File: rtl/proc_control_unit.sv
// Hardwired control unit: steps through fetch (T0-T2) and the opcode-specific
// execute steps, emitting one set of datapath strobes per clock.
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   IR          : instruction register; opcode in the top OP_W bits
//   CON         : branch-condition flip-flop
//   PCout..Rout : register-transfer strobes to the datapath
//   alu_op      : ALU operation, nonzero only in ALU steps
//   run         : 0 once a halt has been executed
module proc_control_unit
  import proc_ctrl_pkg::*;
#(
  parameter int unsigned IR_W = 32,
  parameter int unsigned OP_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [IR_W-1:0] IR,
  input  logic            CON,
  output logic            PCout,
  output logic            PCin,
  output logic            IncPC,
  output logic            MARin,
  output logic            MDRin,
  output logic            MDRout,
  output logic            IRin,
  output logic            Read,
  output logic            Write,
  output logic            Zin,
  output logic            Zlowout,
  output logic            Zhighout,
  output logic            Yin,
  output logic            Cout,
  output logic            BAout,
  output logic            CONin,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            Rin,
  output logic            Rout,
  output logic [OP_W-1:0] alu_op,
  output logic            run
);

  step_e                step_q, step_d;
  op_class_e            op_class;
  logic [OpcodeW-1:0]   opcode;
  logic [OpcodeW-1:0]   imm_alu_op;
  logic [OpcodeW-1:0]   alu_code;
  strobes_t             s;
  logic [IR_W-OpcodeW-1:0] unused_ir_low;

  assign opcode        = IR[IR_W-1 -: OpcodeW];
  assign unused_ir_low = IR[IR_W-OpcodeW-1:0];

  proc_ctrl_opclass u_opclass (
    .opcode_i     (opcode),
    .op_class_o   (op_class),
    .imm_alu_op_o (imm_alu_op)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      step_q <= StT0;
    end else begin
      step_q <= step_d;
    end
  end

  // IR is only written at the end of T2, so the class is first valid in T3.
  // For nop-class opcodes T3 stands in for the next T0 to keep nop at 3 cycles.
  always_comb begin
    step_d = step_q;
    case (step_q)
      StT0: step_d = StT1;
      StT1: step_d = StT2;
      StT2: step_d = StT3;
      StT3: begin
        case (op_class)
          ClsNop:  step_d = StT1;
          ClsHalt: step_d = StHalt;
          ClsJr:   step_d = StT0;
          default: step_d = StT4;
        endcase
      end
      StT4: begin
        case (op_class)
          ClsLd, ClsLdi, ClsSt, ClsRtype, ClsImm, ClsBr: step_d = StT5;
          default: step_d = StT0;
        endcase
      end
      StT5: begin
        case (op_class)
          ClsLd, ClsSt, ClsBr: step_d = StT6;
          default: step_d = StT0;
        endcase
      end
      StT6: begin
        case (op_class)
          ClsLd, ClsSt: step_d = StT7;
          default: step_d = StT0;
        endcase
      end
      StT7:   step_d = StT0;
      StHalt: step_d = StHalt;
      default: step_d = StT0;
    endcase
  end

  always_comb begin
    s        = '0;
    alu_code = '0;
    run      = 1'b1;
    case (step_q)
      StT0: s = fetch_t0_strobes();
      StT1: begin
        s.zlow_out = 1'b1;
        s.pc_in    = 1'b1;
        s.read     = 1'b1;
        s.mdr_in   = 1'b1;
      end
      StT2: begin
        s.mdr_out = 1'b1;
        s.ir_in   = 1'b1;
      end
      StT3: begin
        case (op_class)
          ClsNop:  s = fetch_t0_strobes();
          ClsHalt: run = 1'b0;
          ClsLd, ClsLdi, ClsSt: begin
            s.grb    = 1'b1;
            s.ba_out = 1'b1;
            s.y_in   = 1'b1;
          end
          ClsRtype, ClsImm: begin
            s.grb   = 1'b1;
            s.r_out = 1'b1;
            s.y_in  = 1'b1;
          end
          ClsBr: begin
            s.gra    = 1'b1;
            s.r_out  = 1'b1;
            s.con_in = 1'b1;
          end
          ClsJr: begin
            s.gra   = 1'b1;
            s.r_out = 1'b1;
            s.pc_in = 1'b1;
          end
          default: ;
        endcase
      end
      StT4: begin
        case (op_class)
          ClsLd, ClsLdi, ClsSt: begin
            s.c_out  = 1'b1;
            s.z_in   = 1'b1;
            alu_code = AluAdd;
          end
          ClsRtype: begin
            s.grc    = 1'b1;
            s.r_out  = 1'b1;
            s.z_in   = 1'b1;
            alu_code = opcode;
          end
          ClsImm: begin
            s.c_out  = 1'b1;
            s.z_in   = 1'b1;
            alu_code = imm_alu_op;
          end
          ClsBr: begin
            s.pc_out = 1'b1;
            s.y_in   = 1'b1;
          end
          default: ;
        endcase
      end
      StT5: begin
        case (op_class)
          ClsLd, ClsSt: begin
            s.zlow_out = 1'b1;
            s.mar_in   = 1'b1;
          end
          ClsLdi, ClsRtype, ClsImm: begin
            s.zlow_out = 1'b1;
            s.gra      = 1'b1;
            s.r_in     = 1'b1;
          end
          ClsBr: begin
            s.c_out  = 1'b1;
            s.z_in   = 1'b1;
            alu_code = AluAdd;
          end
          default: ;
        endcase
      end
      StT6: begin
        case (op_class)
          ClsLd: begin
            s.read   = 1'b1;
            s.mdr_in = 1'b1;
          end
          // Read stays low so MDR captures the bus (register value).
          ClsSt: begin
            s.gra    = 1'b1;
            s.r_out  = 1'b1;
            s.mdr_in = 1'b1;
          end
          ClsBr: begin
            s.zlow_out = CON;
            s.pc_in    = CON;
          end
          default: ;
        endcase
      end
      StT7: begin
        case (op_class)
          ClsLd: begin
            s.mdr_out = 1'b1;
            s.gra     = 1'b1;
            s.r_in    = 1'b1;
          end
          ClsSt: s.write = 1'b1;
          default: ;
        endcase
      end
      StHalt: run = 1'b0;
      default: ;
    endcase
    // The reset cycle itself is quiet regardless of where the FSM was.
    if (reset) begin
      s        = '0;
      alu_code = '0;
      run      = 1'b1;
    end
  end

  assign PCout    = s.pc_out;
  assign PCin     = s.pc_in;
  assign IncPC    = s.inc_pc;
  assign MARin    = s.mar_in;
  assign MDRin    = s.mdr_in;
  assign MDRout   = s.mdr_out;
  assign IRin     = s.ir_in;
  assign Read     = s.read;
  assign Write    = s.write;
  assign Zin      = s.z_in;
  assign Zlowout  = s.zlow_out;
  assign Zhighout = s.zhigh_out;
  assign Yin      = s.y_in;
  assign Cout     = s.c_out;
  assign BAout    = s.ba_out;
  assign CONin    = s.con_in;
  assign Gra      = s.gra;
  assign Grb      = s.grb;
  assign Grc      = s.grc;
  assign Rin      = s.r_in;
  assign Rout     = s.r_out;
  assign alu_op   = OP_W'(alu_code);

endmodule

// File: tb/tb_proc_control_unit.sv
// Bench for proc_control_unit. A program of instructions is expanded into an
// expected per-cycle output word list (from the step tables per opcode); the
// driver replays IR/CON/reset per cycle and one process compares every cycle.
module tb_proc_control_unit;

  localparam int unsigned MaxCyc = 512;

  // Output word layout: {run, alu_op[4:0], 21 strobes}
  localparam logic [26:0] MRun     = 27'd1 << 26;
  localparam logic [26:0] MPcOut   = 27'd1 << 20;
  localparam logic [26:0] MPcIn    = 27'd1 << 19;
  localparam logic [26:0] MIncPc   = 27'd1 << 18;
  localparam logic [26:0] MMarIn   = 27'd1 << 17;
  localparam logic [26:0] MMdrIn   = 27'd1 << 16;
  localparam logic [26:0] MMdrOut  = 27'd1 << 15;
  localparam logic [26:0] MIrIn    = 27'd1 << 14;
  localparam logic [26:0] MRead    = 27'd1 << 13;
  localparam logic [26:0] MWrite   = 27'd1 << 12;
  localparam logic [26:0] MZIn     = 27'd1 << 11;
  localparam logic [26:0] MZlowOut = 27'd1 << 10;
  localparam logic [26:0] MYIn     = 27'd1 << 8;
  localparam logic [26:0] MCOut    = 27'd1 << 7;
  localparam logic [26:0] MBaOut   = 27'd1 << 6;
  localparam logic [26:0] MConIn   = 27'd1 << 5;
  localparam logic [26:0] MGra     = 27'd1 << 4;
  localparam logic [26:0] MGrb     = 27'd1 << 3;
  localparam logic [26:0] MGrc     = 27'd1 << 2;
  localparam logic [26:0] MRIn     = 27'd1 << 1;
  localparam logic [26:0] MROut    = 27'd1 << 0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] IR = '0;
  logic        CON = 1'b0;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Read, Write;
  logic Zin, Zlowout, Zhighout, Yin, Cout, BAout, CONin;
  logic Gra, Grb, Grc, Rin, Rout, run;
  logic [4:0] alu_op;
  logic [26:0] dut_word;

  always #5 clk = ~clk;

  proc_control_unit #(.IR_W(32), .OP_W(5)) dut (
    .clk(clk), .reset(reset), .IR(IR), .CON(CON),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Read(Read), .Write(Write),
    .Zin(Zin), .Zlowout(Zlowout), .Zhighout(Zhighout), .Yin(Yin), .Cout(Cout),
    .BAout(BAout), .CONin(CONin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .alu_op(alu_op), .run(run)
  );

  assign dut_word = {run, alu_op, PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Read,
                     Write, Zin, Zlowout, Zhighout, Yin, Cout, BAout, CONin,
                     Gra, Grb, Grc, Rin, Rout};

  // Expected per-cycle stimulus and outputs
  logic [26:0] exp_w [0:MaxCyc-1];
  logic [31:0] ir_v  [0:MaxCyc-1];
  bit          rst_v [0:MaxCyc-1];
  bit          con_v [0:MaxCyc-1];
  int          n_cyc = 0;
  logic [31:0] cur_ir = '0;
  logic [26:0] fetch_w [0:2];
  logic [26:0] ex_w [0:7];
  int          ex_n;

  int s_ld, s_ldi, s_br0, s_br1, s_jr, s_nop, s_after_nop;
  int checks = 0;
  int errors = 0;
  int cur_cyc = 0;
  bit chk_en = 1'b0;

  function automatic logic [26:0] alu(input logic [4:0] a);
    return {1'b0, a, 21'd0};
  endfunction

  task automatic push(input logic [26:0] w, input logic [31:0] ir, input bit rst,
                      input bit con);
    if (n_cyc < MaxCyc) begin
      exp_w[n_cyc] = w;
      ir_v[n_cyc]  = ir;
      rst_v[n_cyc] = rst;
      con_v[n_cyc] = con;
      n_cyc++;
    end
  endtask

  // Execute steps for an instruction, straight from the per-opcode tables.
  task automatic build_exec(input logic [31:0] ir, input bit con);
    logic [4:0] op;
    logic [4:0] ia;
    op   = ir[31:27];
    ex_n = 0;
    if (op <= 5'd2) begin
      ex_w[0] = MRun | MGrb | MBaOut | MYIn;
      ex_w[1] = MRun | MCOut | MZIn | alu(5'd3);
      if (op == 5'd1) begin
        ex_w[2] = MRun | MZlowOut | MGra | MRIn;
        ex_n    = 3;
      end else begin
        ex_w[2] = MRun | MZlowOut | MMarIn;
        if (op == 5'd0) begin
          ex_w[3] = MRun | MRead | MMdrIn;
          ex_w[4] = MRun | MMdrOut | MGra | MRIn;
        end else begin
          ex_w[3] = MRun | MGra | MROut | MMdrIn;
          ex_w[4] = MRun | MWrite;
        end
        ex_n = 5;
      end
    end else if (op <= 5'd10) begin
      ex_w[0] = MRun | MGrb | MROut | MYIn;
      ex_w[1] = MRun | MGrc | MROut | MZIn | alu(op);
      ex_w[2] = MRun | MZlowOut | MGra | MRIn;
      ex_n    = 3;
    end else if (op <= 5'd13) begin
      ia      = (op == 5'd11) ? 5'd3 : (op == 5'd12) ? 5'd9 : 5'd10;
      ex_w[0] = MRun | MGrb | MROut | MYIn;
      ex_w[1] = MRun | MCOut | MZIn | alu(ia);
      ex_w[2] = MRun | MZlowOut | MGra | MRIn;
      ex_n    = 3;
    end else if (op == 5'd18) begin
      ex_w[0] = MRun | MGra | MROut | MConIn;
      ex_w[1] = MRun | MPcOut | MYIn;
      ex_w[2] = MRun | MCOut | MZIn | alu(5'd3);
      ex_w[3] = con ? (MRun | MZlowOut | MPcIn) : MRun;
      ex_n    = 4;
    end else if (op == 5'd19) begin
      ex_w[0] = MRun | MGra | MROut | MPcIn;
      ex_n    = 1;
    end
  endtask

  // abort_at >= 0 replaces that step (counted from T0) with a reset cycle.
  task automatic instr(input logic [31:0] ir, input bit con, input int abort_at);
    build_exec(ir, con);
    for (int k = 0; k < 3 + ex_n; k++) begin
      if (k == abort_at) begin
        push(MRun, cur_ir, 1'b1, con);
        return;
      end
      push((k < 3) ? fetch_w[k] : ex_w[k-3], cur_ir, 1'b0, con);
      if (k == 2) cur_ir = ir;  // datapath loads IR at the end of T2
    end
  endtask

  task automatic halt_instr(input int n_halt);
    for (int k = 0; k < 3; k++) push(fetch_w[k], cur_ir, 1'b0, 1'b0);
    cur_ir = {5'b11010, 27'd0};
    for (int i = 0; i < n_halt; i++) begin
      push(27'd0, cur_ir, 1'b0, i[0]);
      cur_ir = $urandom;
    end
  endtask

  task automatic pin(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL model %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic check_model_pins();
    pin("ld_len", 32'(s_ldi - s_ld), 32'd8);
    pin("ld_t4", 32'(exp_w[s_ld+4]), 32'h0460_0880);
    pin("ld_t7", 32'(exp_w[s_ld+7]), 32'h0400_8012);
    pin("br_len", 32'(s_br1 - s_br0), 32'd7);
    pin("br0_t6", 32'(exp_w[s_br0+6]), 32'h0400_0000);
    pin("br1_t6", 32'(exp_w[s_br1+6]), 32'h0408_0400);
    pin("jr_len", 32'(s_nop - s_jr), 32'd4);
    pin("nop_len", 32'(s_after_nop - s_nop), 32'd3);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (cur_cyc == 0) check_model_pins();
      checks++;
      if (dut_word !== exp_w[cur_cyc]) begin
        errors++;
        $display("FAIL cycle %0d outputs: got %h want %h (IR=%h reset=%0b CON=%0b)",
                 cur_cyc, dut_word, exp_w[cur_cyc], ir_v[cur_cyc], rst_v[cur_cyc],
                 con_v[cur_cyc]);
      end
    end
  end

  initial begin
    fetch_w[0] = MRun | MPcOut | MMarIn | MIncPc | MZIn;
    fetch_w[1] = MRun | MZlowOut | MPcIn | MRead | MMdrIn;
    fetch_w[2] = MRun | MMdrOut | MIrIn;

    push(MRun, cur_ir, 1'b1, 1'b0);
    s_ld = n_cyc;
    instr({5'b00000, 4'd1, 4'd0, 4'd0, 15'd85}, 1'b0, -1);
    s_ldi = n_cyc;
    instr({5'b00001, 4'd2, 4'd1, 4'd0, 15'd35}, 1'b0, -1);
    instr({5'b00011, 4'd3, 4'd1, 4'd2, 15'd0}, 1'b1, -1);   // add
    instr({5'b01100, 4'd4, 4'd3, 4'd0, 15'd7}, 1'b0, -1);   // andi
    instr({5'b00100, 4'd5, 4'd1, 4'd2, 15'd0}, 1'b0, -1);   // sub
    instr({5'b00101, 4'd5, 4'd1, 4'd2, 15'd0}, 1'b0, -1);   // shr
    instr({5'b00110, 4'd5, 4'd1, 4'd2, 15'd0}, 1'b0, -1);   // shl
    instr({5'b00111, 4'd5, 4'd1, 4'd2, 15'd0}, 1'b0, -1);   // ror
    instr({5'b01000, 4'd5, 4'd1, 4'd2, 15'd0}, 1'b0, -1);   // rol
    instr({5'b01001, 4'd5, 4'd1, 4'd2, 15'd0}, 1'b0, -1);   // and
    instr({5'b01010, 4'd5, 4'd1, 4'd2, 15'd0}, 1'b0, -1);   // or
    instr({5'b01011, 4'd6, 4'd1, 4'd0, 15'd9}, 1'b0, -1);   // addi
    instr({5'b01101, 4'd6, 4'd1, 4'd0, 15'd9}, 1'b0, -1);   // ori
    instr({5'b00010, 4'd7, 4'd1, 4'd0, 15'd20}, 1'b0, -1);  // st
    s_br0 = n_cyc;
    instr({5'b10010, 4'd2, 4'd0, 4'd0, 15'd12}, 1'b0, -1);
    s_br1 = n_cyc;
    instr({5'b10010, 4'd2, 4'd0, 4'd0, 15'd12}, 1'b1, -1);
    s_jr = n_cyc;
    instr({5'b10011, 4'd3, 4'd0, 4'd0, 15'd0}, 1'b0, -1);
    s_nop = n_cyc;
    instr({5'b11001, 27'd0}, 1'b0, -1);
    s_after_nop = n_cyc;
    instr({5'b01110, 27'd5}, 1'b0, -1);                     // unlisted
    instr({5'b10100, 27'd5}, 1'b1, -1);                     // unlisted
    instr({5'b11111, 27'd5}, 1'b0, -1);                     // unlisted
    instr({5'b01011, 4'd1, 4'd1, 4'd0, 15'd1}, 1'b0, -1);   // addi after nop-class
    instr({5'b00010, 4'd7, 4'd1, 4'd0, 15'd20}, 1'b0, 4);   // st, reset in T4
    instr({5'b00000, 4'd8, 4'd0, 4'd0, 15'd3}, 1'b0, -1);   // ld
    halt_instr(20);
    push(MRun, cur_ir, 1'b1, 1'b0);
    instr({5'b00001, 4'd9, 4'd0, 4'd0, 15'd4}, 1'b0, -1);   // ldi after halt

    for (int c = 0; c < n_cyc; c++) begin
      @(posedge clk);
      #1;
      reset   = rst_v[c];
      IR      = ir_v[c];
      CON     = con_v[c];
      cur_cyc = c;
      chk_en  = 1'b1;
    end
    @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
